// File: rtl/axi_cdma_desc_split_pkg.sv
// Shared state encoding and address-boundary constant for the CDMA descriptor splitter.
package axi_cdma_desc_split_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_e;

   localparam int unsigned BOUNDARY_4K = 4096;

endpackage

// File: rtl/axi_cdma_desc_split_if.sv
// Job, segment and status channels of the descriptor splitter.
// The DUT connects through the slave modport; the surrounding logic uses master.
interface axi_cdma_desc_split_if #(
   parameter int unsigned AXI_ADDR_WIDTH = 16,
   parameter int unsigned LEN_WIDTH      = 20,
   parameter int unsigned TAG_WIDTH      = 8
);
   logic [AXI_ADDR_WIDTH-1:0] s_axis_desc_read_addr;
   logic [AXI_ADDR_WIDTH-1:0] s_axis_desc_write_addr;
   logic [LEN_WIDTH-1:0]      s_axis_desc_len;
   logic [TAG_WIDTH-1:0]      s_axis_desc_tag;
   logic                      s_axis_desc_valid;
   logic                      s_axis_desc_ready;

   logic [AXI_ADDR_WIDTH-1:0] m_axis_desc_read_addr;
   logic [AXI_ADDR_WIDTH-1:0] m_axis_desc_write_addr;
   logic [LEN_WIDTH-1:0]      m_axis_desc_len;
   logic [TAG_WIDTH-1:0]      m_axis_desc_tag;
   logic                      m_axis_desc_valid;
   logic                      m_axis_desc_ready;

   logic [TAG_WIDTH-1:0]      s_axis_desc_status_tag;
   logic                      s_axis_desc_status_valid;
   logic [TAG_WIDTH-1:0]      m_axis_desc_status_tag;
   logic                      m_axis_desc_status_valid;

   modport slave (
      input  s_axis_desc_read_addr, s_axis_desc_write_addr, s_axis_desc_len,
      input  s_axis_desc_tag, s_axis_desc_valid,
      output s_axis_desc_ready,
      output m_axis_desc_read_addr, m_axis_desc_write_addr, m_axis_desc_len,
      output m_axis_desc_tag, m_axis_desc_valid,
      input  m_axis_desc_ready,
      input  s_axis_desc_status_tag, s_axis_desc_status_valid,
      output m_axis_desc_status_tag, m_axis_desc_status_valid
   );

   modport master (
      output s_axis_desc_read_addr, s_axis_desc_write_addr, s_axis_desc_len,
      output s_axis_desc_tag, s_axis_desc_valid,
      input  s_axis_desc_ready,
      input  m_axis_desc_read_addr, m_axis_desc_write_addr, m_axis_desc_len,
      input  m_axis_desc_tag, m_axis_desc_valid,
      output m_axis_desc_ready,
      output s_axis_desc_status_tag, s_axis_desc_status_valid,
      input  m_axis_desc_status_tag, m_axis_desc_status_valid
   );

endinterface

// File: rtl/axi_cdma_seg_len_calc.sv
// Combinational segment length: min(remaining, MAX_SEG_LEN), further clipped to the next
// 4 KiB boundary of both addresses when AXI_CDMA_DESC_SPLIT_4K_EN is defined.
module axi_cdma_seg_len_calc
   import axi_cdma_desc_split_pkg::*;
#(
   parameter int unsigned AXI_ADDR_WIDTH = 16,
   parameter int unsigned LEN_WIDTH      = 20,
   parameter int unsigned MAX_SEG_LEN    = 4096
) (
   input  logic [LEN_WIDTH-1:0]      rem_i,
   input  logic [AXI_ADDR_WIDTH-1:0] rd_addr_i,
   input  logic [AXI_ADDR_WIDTH-1:0] wr_addr_i,
   output logic [LEN_WIDTH-1:0]      seg_len_c_o
);

`ifdef AXI_CDMA_DESC_SPLIT_4K_EN
   localparam bit BOUNDARY_EN = 1'b1;
`else
   localparam bit BOUNDARY_EN = 1'b0;
`endif

   localparam logic [AXI_ADDR_WIDTH-1:0] PAGE_MASK = AXI_ADDR_WIDTH'(BOUNDARY_4K - 1);

   logic [LEN_WIDTH-1:0] rd_lim_c;
   logic [LEN_WIDTH-1:0] wr_lim_c;

   // Bytes left before each address crosses into the next 4 KiB page.
   always_comb begin
      rd_lim_c = LEN_WIDTH'(BOUNDARY_4K) - LEN_WIDTH'(rd_addr_i & PAGE_MASK);
      wr_lim_c = LEN_WIDTH'(BOUNDARY_4K) - LEN_WIDTH'(wr_addr_i & PAGE_MASK);
   end

   always_comb begin
      seg_len_c_o = rem_i;
      if (seg_len_c_o > LEN_WIDTH'(MAX_SEG_LEN)) seg_len_c_o = LEN_WIDTH'(MAX_SEG_LEN);
      if (BOUNDARY_EN && (seg_len_c_o > rd_lim_c)) seg_len_c_o = rd_lim_c;
      if (BOUNDARY_EN && (seg_len_c_o > wr_lim_c)) seg_len_c_o = wr_lim_c;
   end

endmodule

// File: rtl/axi_cdma_desc_split.sv
// Splits one CDMA copy job into MAX_SEG_LEN segments and reports job completion once all
// segment statuses are back. Optional 4 KiB splitting: define AXI_CDMA_DESC_SPLIT_4K_EN.
module axi_cdma_desc_split
   import axi_cdma_desc_split_pkg::*;
#(
   parameter int unsigned AXI_ADDR_WIDTH = 16,
   parameter int unsigned LEN_WIDTH      = 20,
   parameter int unsigned TAG_WIDTH      = 8,
   parameter int unsigned MAX_SEG_LEN    = 4096
) (
   input  logic                   clk,
   input  logic                   rst_n,
   axi_cdma_desc_split_if.slave   desc_if,
   output logic                   status_error
);

   state_e                    state_q;
   logic                      s_ready_q;
   logic                      m_valid_q;
   logic [AXI_ADDR_WIDTH-1:0] m_rd_q;
   logic [AXI_ADDR_WIDTH-1:0] m_wr_q;
   logic [LEN_WIDTH-1:0]      m_len_q;
   logic [TAG_WIDTH-1:0]      m_tag_q;
   logic [LEN_WIDTH-1:0]      rem_q;
   logic [LEN_WIDTH-1:0]      out_q;
   logic [LEN_WIDTH-1:0]      out_d;
   logic                      st_valid_q;
   logic [TAG_WIDTH-1:0]      st_tag_q;
   logic                      err_q;

   logic                      accept_c;
   logic                      hs_c;
   logic                      dec_c;
   logic                      stray_c;
   logic [AXI_ADDR_WIDTH-1:0] nxt_rd_c;
   logic [AXI_ADDR_WIDTH-1:0] nxt_wr_c;
   logic [LEN_WIDTH-1:0]      calc_rem_c;
   logic [AXI_ADDR_WIDTH-1:0] calc_rd_c;
   logic [AXI_ADDR_WIDTH-1:0] calc_wr_c;
   logic [LEN_WIDTH-1:0]      seg_len_c;

   // Only one job is in flight, so the returned status tag carries no information.
   logic unused_status_tag_c;
   assign unused_status_tag_c = ^desc_if.s_axis_desc_status_tag;

   assign accept_c = desc_if.s_axis_desc_valid && s_ready_q;
   assign hs_c     = m_valid_q && desc_if.m_axis_desc_ready;
   assign stray_c  = desc_if.s_axis_desc_status_valid && (out_q == '0) && !hs_c;
   assign dec_c    = desc_if.s_axis_desc_status_valid && !stray_c;
   assign out_d    = out_q + LEN_WIDTH'(hs_c) - LEN_WIDTH'(dec_c);
   assign nxt_rd_c = m_rd_q + AXI_ADDR_WIDTH'(m_len_q);
   assign nxt_wr_c = m_wr_q + AXI_ADDR_WIDTH'(m_len_q);

   // In IDLE the first segment is sized from the incoming job so it can be valid next cycle.
   always_comb begin
      calc_rem_c = rem_q;
      calc_rd_c  = nxt_rd_c;
      calc_wr_c  = nxt_wr_c;
      if (state_q == ST_IDLE) begin
         calc_rem_c = desc_if.s_axis_desc_len;
         calc_rd_c  = desc_if.s_axis_desc_read_addr;
         calc_wr_c  = desc_if.s_axis_desc_write_addr;
      end
   end

   axi_cdma_seg_len_calc #(
      .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH),
      .LEN_WIDTH      (LEN_WIDTH),
      .MAX_SEG_LEN    (MAX_SEG_LEN)
   ) u_seg_len_calc (
      .rem_i       (calc_rem_c),
      .rd_addr_i   (calc_rd_c),
      .wr_addr_i   (calc_wr_c),
      .seg_len_c_o (seg_len_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         s_ready_q  <= 1'b0;
         m_valid_q  <= 1'b0;
         m_rd_q     <= '0;
         m_wr_q     <= '0;
         m_len_q    <= '0;
         m_tag_q    <= '0;
         rem_q      <= '0;
         out_q      <= '0;
         st_valid_q <= 1'b0;
         st_tag_q   <= '0;
         err_q      <= 1'b0;
      end else begin
         out_q      <= out_d;
         st_valid_q <= 1'b0;
         if (stray_c) err_q <= 1'b1;
         unique case (state_q)
            ST_IDLE: begin
               s_ready_q <= 1'b1;
               if (accept_c) begin
                  m_tag_q <= desc_if.s_axis_desc_tag;
                  if (desc_if.s_axis_desc_len == '0) begin
                     st_valid_q <= 1'b1;
                     st_tag_q   <= desc_if.s_axis_desc_tag;
                  end else begin
                     s_ready_q <= 1'b0;
                     m_valid_q <= 1'b1;
                     m_rd_q    <= desc_if.s_axis_desc_read_addr;
                     m_wr_q    <= desc_if.s_axis_desc_write_addr;
                     m_len_q   <= seg_len_c;
                     rem_q     <= desc_if.s_axis_desc_len - seg_len_c;
                     state_q   <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               if (hs_c) begin
                  if (rem_q != '0) begin
                     m_rd_q  <= nxt_rd_c;
                     m_wr_q  <= nxt_wr_c;
                     m_len_q <= seg_len_c;
                     rem_q   <= rem_q - seg_len_c;
                  end else begin
                     m_valid_q <= 1'b0;
                     if (out_d == '0) begin
                        state_q    <= ST_IDLE;
                        s_ready_q  <= 1'b1;
                        st_valid_q <= 1'b1;
                        st_tag_q   <= m_tag_q;
                     end else begin
                        state_q <= ST_WAIT;
                     end
                  end
               end
            end
            ST_WAIT: begin
               if (out_d == '0) begin
                  state_q    <= ST_IDLE;
                  s_ready_q  <= 1'b1;
                  st_valid_q <= 1'b1;
                  st_tag_q   <= m_tag_q;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign desc_if.s_axis_desc_ready        = s_ready_q;
   assign desc_if.m_axis_desc_valid        = m_valid_q;
   assign desc_if.m_axis_desc_read_addr    = m_rd_q;
   assign desc_if.m_axis_desc_write_addr   = m_wr_q;
   assign desc_if.m_axis_desc_len          = m_len_q;
   assign desc_if.m_axis_desc_tag          = m_tag_q;
   assign desc_if.m_axis_desc_status_valid = st_valid_q;
   assign desc_if.m_axis_desc_status_tag   = st_tag_q;
   assign status_error                     = err_q;

endmodule
